// File: rtl/motor_pkg.sv
// Shared constants, direction type and command decode for the wheel PWM drive.
package motor_pkg;

  localparam int unsigned PERIOD_CYCLES = 1_000_000;
  localparam int unsigned PULSE_FWD     = 100_000;
  localparam int unsigned PULSE_REV     = 50_000;
  localparam int unsigned PULSE_STOP    = 75_000;
  localparam int unsigned CNT_W         = 20;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } dir_t;

  // A conflicting request (both asserted) is treated as stop.
  function automatic dir_t decode_dir(input logic fwd, input logic bwd);
    case ({fwd, bwd})
      2'b10:   return FWD;
      2'b01:   return REV;
      default: return STOP;
    endcase
  endfunction

endpackage

// File: rtl/motor_if.sv
// Command/output bundle of one wheel drive: direction requests in, PWM line out.
interface motor_if;
  logic forward;
  logic backward;
  logic signal;

  modport master (output forward, output backward, input signal);
  modport slave  (input forward, input backward, output signal);
endinterface

// File: rtl/motor_pwm_gen.sv
// Free-running frame counter with a registered compare against the supplied width.
module pwm_gen
  import motor_pkg::*;
#(
  parameter int unsigned G_PERIOD = PERIOD_CYCLES,
  parameter int unsigned G_CNT_W  = CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [G_CNT_W-1:0] i_width,
  output logic               o_pwm,
  output logic               o_frame_end
);

  localparam logic [G_CNT_W-1:0] LAST = G_CNT_W'(G_PERIOD - 1);

  logic [G_CNT_W-1:0] r_cnt;
  logic               r_pwm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + G_CNT_W'(1);
      r_pwm <= (r_cnt < i_width);
    end
  end

  assign o_pwm       = r_pwm;
  assign o_frame_end = (r_cnt == LAST);

endmodule

// File: rtl/motor_top.sv
// One wheel: decodes the direction command and latches the pulse width only at the
// frame boundary, so a mid-frame command change never produces a runt or stretched pulse.
module motor_top
  import motor_pkg::*;
#(
  parameter int unsigned G_PERIOD     = PERIOD_CYCLES,
  parameter int unsigned G_PULSE_FWD  = PULSE_FWD,
  parameter int unsigned G_PULSE_REV  = PULSE_REV,
  parameter int unsigned G_PULSE_STOP = PULSE_STOP,
  parameter int unsigned G_CNT_W      = CNT_W
) (
  input logic   clk,
  input logic   rst_n,
  motor_if.slave bus
);

  localparam logic [G_CNT_W-1:0] W_FWD  = G_CNT_W'(G_PULSE_FWD);
  localparam logic [G_CNT_W-1:0] W_REV  = G_CNT_W'(G_PULSE_REV);
  localparam logic [G_CNT_W-1:0] W_STOP = G_CNT_W'(G_PULSE_STOP);

  dir_t               w_dir;
  logic [G_CNT_W-1:0] w_width_next;
  logic [G_CNT_W-1:0] r_width;
  logic               w_frame_end;
  logic               w_pwm;

  assign w_dir = decode_dir(bus.forward, bus.backward);

  always_comb begin
    w_width_next = W_STOP;
    case (w_dir)
      FWD:     w_width_next = W_FWD;
      REV:     w_width_next = W_REV;
      default: w_width_next = W_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_width <= W_STOP;
    end else if (w_frame_end) begin
      r_width <= w_width_next;
    end
  end

  pwm_gen #(
    .G_PERIOD (G_PERIOD),
    .G_CNT_W  (G_CNT_W)
  ) u_pwm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_width     (r_width),
    .o_pwm       (w_pwm),
    .o_frame_end (w_frame_end)
  );

  assign bus.signal = w_pwm;

endmodule

// File: tb/tb_motor_top.sv
// Directed bench for motor_top: expected pulse widths are queued when commands are
// driven and compared against high-time and period measured on the PWM line.
module tb_motor_top;

  localparam int PERIOD = 1000;

  logic clk;
  logic rst_n;
  int   cyc;

  motor_if bus ();

  motor_top #(
    .G_PERIOD     (1000),
    .G_PULSE_FWD  (100),
    .G_PULSE_REV  (50),
    .G_PULSE_STOP (75),
    .G_CNT_W      (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int exp_q[$];
  int obs_q[$];
  int per_q[$];
  int n_asserts;
  int n_fails;

  // Line monitor: high-run lengths and rise-to-rise intervals, ignored while in reset.
  initial begin
    logic prev_sig;
    int   run;
    int   rise_cyc;
    bit   have_rise;
    prev_sig  = 1'b0;
    run       = 0;
    rise_cyc  = 0;
    have_rise = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_sig  = 1'b0;
        run       = 0;
        have_rise = 1'b0;
      end else begin
        if (bus.signal === 1'b1) run++;
        if (bus.signal === 1'b1 && prev_sig !== 1'b1) begin
          if (have_rise) per_q.push_back(cyc - rise_cyc);
          rise_cyc  = cyc;
          have_rise = 1'b1;
        end
        if (bus.signal !== 1'b1 && prev_sig === 1'b1) begin
          obs_q.push_back(run);
          run = 0;
        end
        prev_sig = bus.signal;
      end
    end
  end

  function automatic int exp_width(input logic f, input logic b);
    if (f && !b) return 100;
    if (!f && b) return 50;
    return 75;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_frame();
    int w;
    int e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    if (obs_q.size() == 0) begin
      chk("pulse_present", 0, 1);
    end else begin
      w = obs_q.pop_front();
      chk("width", w, e);
    end
    while (per_q.size() > 0) chk("period", per_q.pop_front(), PERIOD);
  endtask

  // Called just after a frame start; drives the command at counter=off, which sets the next frame.
  task automatic frame(input logic f, input logic b, input int off);
    repeat (off) @(negedge clk);
    bus.forward  = f;
    bus.backward = b;
    exp_q.push_back(exp_width(f, b));
    repeat (PERIOD - off) @(negedge clk);
    #1;
    check_frame();
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("first_cycle_high", {31'b0, bus.signal}, 1);
    exp_q.push_back(75);
  endtask

  initial begin
    cyc          = 0;
    n_asserts    = 0;
    n_fails      = 0;
    rst_n        = 1'b0;
    bus.forward  = 1'b0;
    bus.backward = 1'b0;

    // 1. reset, then neutral frames
    repeat (5) begin
      @(negedge clk);
      chk("reset_low", {31'b0, bus.signal}, 0);
    end
    release_reset();
    frame(1'b0, 1'b0, 10);
    frame(1'b0, 1'b0, 500);

    // 2. forward held
    frame(1'b1, 1'b0, 10);
    frame(1'b1, 1'b0, 10);
    frame(1'b1, 1'b0, 998);

    // 3. backward, then conflicting command
    frame(1'b0, 1'b1, 10);
    frame(1'b0, 1'b1, 10);
    frame(1'b1, 1'b1, 10);
    frame(1'b1, 1'b1, 10);

    // 4. forward raised at counter 30 of a stop frame
    frame(1'b0, 1'b0, 10);
    frame(1'b1, 1'b0, 30);
    frame(1'b1, 1'b0, 10);

    // 5. reset at counter 60 of a forward frame
    repeat (59) @(negedge clk);
    chk("pre_reset_high", {31'b0, bus.signal}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_reset_low", {31'b0, bus.signal}, 0);
    chk("no_runt_recorded", obs_q.size(), 0);
    exp_q.delete();
    per_q.delete();
    repeat (2) @(negedge clk);
    chk("held_reset_low", {31'b0, bus.signal}, 0);
    release_reset();
    frame(1'b1, 1'b0, 10);
    frame(1'b1, 1'b0, 10);

    // 6. command changes every frame
    for (int i = 0; i < 10; i++) begin
      case (i % 4)
        0:       frame(1'b0, 1'b1, 20 + i);
        1:       frame(1'b1, 1'b1, 20 + i);
        2:       frame(1'b1, 1'b0, 20 + i);
        default: frame(1'b0, 1'b0, 20 + i);
      endcase
    end

    chk("no_extra_pulses", obs_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
